// File: rtl/sin_arg_scheduler.sv
// sin_arg_scheduler: range reduction front end for a sine unit.
// Accepts one single-precision angle, removes whole multiples of 2*pi with a
// shared external combinational adder, then folds the residue into [0, pi/2]
// and reports the quadrant, the original sign and an overflow flag.
module sin_arg_scheduler #(
  parameter int MAX_ITER = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_quadrant,
  output logic        out_neg,
  output logic        out_overflow,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic [4:0]  add_ctrl,
  input  logic [31:0] add_result
);

  localparam logic [31:0] HALF_PI       = 32'h3FC90FDB;
  localparam logic [31:0] PI            = 32'h40490FDB;
  localparam logic [31:0] THREE_HALF_PI = 32'h4096CBE4;
  localparam logic [31:0] TWO_PI        = 32'h40C90FDB;
  localparam logic [4:0]  CTRL_SUB      = 5'b10000;
  localparam logic [4:0]  CTRL_IDLE     = 5'b00000;

  localparam int          IW       = $clog2(MAX_ITER + 1);
  localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    FOLD   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [31:0]   mag;
  logic          neg;
  logic          overflow;
  logic [IW-1:0] iter;

  // Magnitude classification. mag always has bit 31 clear, so positive IEEE
  // values order the same way as their 31-bit integer encodings.
  logic       mag_special;
  logic       above_two_pi;
  logic       iter_left;
  logic [1:0] fold_q;
  logic       reduce_sub;
  logic       fold_sub;
  logic [31:0] sub_result;

  assign mag_special  = (mag[30:23] == 8'hFF);
  assign above_two_pi = (mag[30:0] > TWO_PI[30:0]);
  assign iter_left    = (iter < ITER_MAX);

  // The adder hands back a signed value; the folds and reductions here only
  // ever produce non-negative results, so the sign bit is dropped.
  assign sub_result = {1'b0, add_result[30:0]};

  // Quadrant of the reduced residue, upper limits inclusive.
  always_comb begin
    fold_q = 2'd3;
    if (mag[30:0] <= HALF_PI[30:0]) begin
      fold_q = 2'd0;
    end else if (mag[30:0] <= PI[30:0]) begin
      fold_q = 2'd1;
    end else if (mag[30:0] <= THREE_HALF_PI[30:0]) begin
      fold_q = 2'd2;
    end
  end

  assign reduce_sub = (state == REDUCE) && !mag_special && above_two_pi && iter_left;
  assign fold_sub   = (state == FOLD) && !overflow && (fold_q != 2'd0);

  // Adder operand mux: only one subtraction can be in flight per cycle, and
  // the bus is parked at zero whenever nothing is issued.
  always_comb begin
    add_a    = 32'h0;
    add_b    = 32'h0;
    add_ctrl = CTRL_IDLE;
    if (reduce_sub) begin
      add_a    = mag;
      add_b    = TWO_PI;
      add_ctrl = CTRL_SUB;
    end else if (fold_sub) begin
      add_ctrl = CTRL_SUB;
      case (fold_q)
        2'd1: begin
          add_a = PI;
          add_b = mag;
        end
        2'd2: begin
          add_a = mag;
          add_b = PI;
        end
        default: begin
          add_a = TWO_PI;
          add_b = mag;
        end
      endcase
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= 32'h0;
      out_quadrant <= 2'd0;
      out_neg      <= 1'b0;
      out_overflow <= 1'b0;
      mag          <= 32'h0;
      neg          <= 1'b0;
      overflow     <= 1'b0;
      iter         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mag      <= {1'b0, in_data[30:0]};
            neg      <= in_data[31];
            overflow <= 1'b0;
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= REDUCE;
          end else begin
            // First edge after reset (or any idle edge) opens the input.
            in_ready <= 1'b1;
          end
        end

        REDUCE: begin
          if (mag_special) begin
            // NaN or infinity cannot be reduced; pass it through untouched.
            overflow <= 1'b1;
            state    <= FOLD;
          end else if (above_two_pi) begin
            if (iter_left) begin
              mag  <= sub_result;
              iter <= iter + 1'b1;
            end else begin
              overflow <= 1'b1;
              state    <= FOLD;
            end
          end else begin
            state <= FOLD;
          end
        end

        FOLD: begin
          out_neg      <= neg;
          out_overflow <= overflow;
          out_valid    <= 1'b1;
          state        <= DONE;
          if (overflow) begin
            out_data     <= mag;
            out_quadrant <= 2'd0;
          end else begin
            out_quadrant <= fold_q;
            out_data     <= (fold_q == 2'd0) ? mag : sub_result;
          end
        end

        DONE: begin
          // Results hold until taken; the input reopens only afterwards so a
          // waiting producer never overlaps with an unconsumed result.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sin_arg_scheduler.sv
// Directed bench for sin_arg_scheduler with a behavioural single-precision
// subtractor standing in for the shared fpadd.
module tb_sin_arg_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_quadrant;
  logic        out_neg;
  logic        out_overflow;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [4:0]  add_ctrl;
  logic [31:0] add_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sin_arg_scheduler #(.MAX_ITER(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_quadrant (out_quadrant),
    .out_neg      (out_neg),
    .out_overflow (out_overflow),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_ctrl     (add_ctrl),
    .add_result   (add_result)
  );

  // a - b for positive normal a >= b, round to nearest even.
  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    logic [75:0] x, y, mb, diff, keep, rem, half;
    logic        sticky;
    int          d, p, s, e;
    if (b[30:0] == 31'h0) return {1'b0, a[30:0]};
    if (a[30:0] == b[30:0]) return 32'h0;
    x  = {52'h0, 1'b1, a[22:0]} << 26;
    mb = {52'h0, 1'b1, b[22:0]} << 26;
    d  = int'(a[30:23]) - int'(b[30:23]);
    if (d >= 60) begin
      y = 76'h0;
      sticky = 1'b1;
    end else begin
      y = mb >> d;
      sticky = ((y << d) != mb);
    end
    diff = x - y;
    if (sticky) diff = diff - 76'd1;
    p = 0;
    for (int i = 0; i < 76; i++) if (diff[i]) p = i;
    e = int'(a[30:23]) - (49 - p);
    if (p >= 23) begin
      s    = p - 23;
      keep = diff >> s;
      rem  = diff & ((76'd1 << s) - 76'd1);
      half = (s > 0) ? (76'd1 << (s - 1)) : 76'h0;
      if (s > 0 && (rem > half || (rem == half && (sticky || keep[0])))) keep = keep + 76'd1;
      if (keep[24]) begin
        keep = keep >> 1;
        e = e + 1;
      end
    end else begin
      keep = diff << (23 - p);
    end
    return {1'b0, e[7:0], keep[22:0]};
  endfunction

  assign add_result = (add_ctrl == 5'b10000) ? fp_sub(add_a, add_b) : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one operand, wait for the result and check it, latency, and the
  // number of adder subtractions issued on the way.
  task automatic run_op(input string tag, input logic [31:0] din, input logic [31:0] exp_data,
                        input logic [1:0] exp_q, input logic exp_neg, input logic exp_ovf,
                        input int exp_lat, input int exp_subs);
    int   lat, subs, w;
    logic bus_bad;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = din;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'h0;
    lat = 0;
    subs = 0;
    bus_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (add_ctrl == 5'b10000) subs++;
      else if (add_ctrl != 5'b0 || add_a != 32'h0 || add_b != 32'h0) bus_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    $display("op %s in=%h out=%h q=%0d neg=%0d ovf=%0d lat=%0d subs=%0d",
             tag, din, out_data, out_quadrant, out_neg, out_overflow, lat, subs);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/subs"}, 32'(subs), 32'(exp_subs));
    check({tag, "/bus_idle"}, 32'(bus_bad), 32'd0);
    check({tag, "/data"}, out_data, exp_data);
    check({tag, "/quadrant"}, 32'(out_quadrant), 32'(exp_q));
    check({tag, "/neg"}, 32'(out_neg), 32'(exp_neg));
    check({tag, "/overflow"}, 32'(out_overflow), 32'(exp_ovf));
  endtask

  // Hold the result for 'hold' cycles (optionally with a new operand already
  // offered), then take it and check the input reopens on the next cycle.
  task automatic handshake(input string tag, input int hold, input logic offer);
    logic [35:0] snap;
    logic        stable, rdy_seen;
    snap = {out_data, out_quadrant, out_neg, out_overflow};
    stable = 1'b1;
    rdy_seen = 1'b0;
    if (offer) begin
      in_valid = 1'b1;
      in_data  = 32'h3F800000;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if ({out_data, out_quadrant, out_neg, out_overflow} !== snap || !out_valid) stable = 1'b0;
      if (in_ready) rdy_seen = 1'b1;
    end
    if (hold > 0) begin
      check({tag, "/stable"}, 32'(stable), 32'd1);
      check({tag, "/in_ready_held"}, 32'(rdy_seen), 32'd0);
    end
    check({tag, "/in_ready_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "/in_ready_rise"}, 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  initial begin
    logic [31:0] big;
    logic        seen_valid;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst/in_ready", 32'(in_ready), 32'd0);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/out_data", out_data, 32'h0);
    check("rst/add_bus", {add_ctrl, add_a[26:0]} | add_b, 32'h0);
    reset = 1'b0;
    #1 check("rel/in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rel/in_ready_after_edge", 32'(in_ready), 32'd1);

    // 1.0 is already in [0, pi/2].
    run_op("one", 32'h3F800000, 32'h3F800000, 2'd0, 1'b0, 1'b0, 2, 0);
    handshake("one", 0, 1'b0);

    // -4.0: |x| in (pi, 3pi/2], out = 4 - pi.
    run_op("neg4", 32'hC0800000, 32'h3F5BC094, 2'd2, 1'b1, 1'b0, 2, 1);
    handshake("neg4", 0, 1'b0);

    // 10.0: one pass gives 3.7168 (0x406DE04A), in (pi, 3pi/2], out = 3.7168 - pi.
    // Result is held back for 5 cycles with the next operand already offered.
    run_op("ten", 32'h41200000, 32'h3F1341BC, 2'd2, 1'b0, 1'b0, 3, 2);
    handshake("ten", 5, 1'b1);

    // Exactly pi lands in quadrant 1 and folds to +0.
    run_op("pi", 32'h40490FDB, 32'h00000000, 2'd1, 1'b0, 1'b0, 2, 1);
    handshake("pi", 0, 1'b0);

    // +Inf passes through as overflow.
    run_op("inf", 32'h7F800000, 32'h7F800000, 2'd0, 1'b0, 1'b1, 2, 0);
    handshake("inf", 0, 1'b0);

    // 1e6 exhausts all 16 passes.
    big = 32'h49742400;
    for (int i = 0; i < 16; i++) big = fp_sub(big, 32'h40C90FDB);
    run_op("1e6", 32'h49742400, big, 2'd0, 1'b0, 1'b1, 18, 16);
    handshake("1e6", 0, 1'b0);

    // Reset in the middle of a long reduction drops the operand.
    in_valid = 1'b1;
    in_data  = 32'h49742400;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'h0;
    repeat (4) @(negedge clk);
    check("midrst/busy", 32'(add_ctrl), 32'h10);
    reset = 1'b1;
    #1;
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    check("midrst/in_ready", 32'(in_ready), 32'd0);
    check("midrst/add_ctrl", 32'(add_ctrl), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("midrst/in_ready_released", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("midrst/in_ready_edge", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("midrst/no_output", 32'(seen_valid), 32'd0);

    // Block still works after the abort.
    run_op("post", 32'h3F800000, 32'h3F800000, 2'd0, 1'b0, 1'b0, 2, 0);
    handshake("post", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
